router_fsm: RTL

Packet-control state machine for the 1x3 router. It sits upstream of the three output FIFOs and of the register/parity block. It decodes the header address, sequences header/payload/parity loading, and produces `lfd_state` and the write-enable strobes that drive FIFO writes. It stalls the source with `busy` whenever the selected FIFO cannot accept data.

---
 rtl/router_fsm_pkg.sv | 19 +
 rtl/router_fsm_if.sv | 40 ++++
 rtl/router_fsm.sv | 94 +++++++++
 3 files changed

// File: rtl/router_fsm_pkg.sv
// Shared types and constants for the 1x3 router packet-control FSM.
package router_pkg;

    localparam int         NUM_PORTS    = 3;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    // 3-bit binary encoding; synthesis may re-encode as one-hot.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        CHECK_PARITY_ERROR = 3'd4,
        FIFO_FULL_STATE    = 3'd5,
        LOAD_AFTER_FULL    = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

endpackage

// File: rtl/router_fsm_if.sv
// Control/status bundle between the router FSM and its surroundings
// (source, FIFO flags, synchronizer, register block).
interface router_fsm_if #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    data_in;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic                 parity_done;
    logic                 low_pkt_valid;

    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 rst_int_reg;
    logic                 write_enb_reg;
    logic                 busy;
    logic [ADDR_W-1:0]    addr_q;

    // Environment side: drives packet/flag inputs, observes FSM outputs.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, addr_q
    );

    // FSM side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
               parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
               rst_int_reg, write_enb_reg, busy, addr_q
    );
endinterface

// File: rtl/router_fsm.sv
// Router packet-control FSM: decodes the header address, sequences
// header/payload/parity loading and stalls the source when the selected
// FIFO cannot accept data. Outputs are Moore, decoded from the state.
module router_fsm #(
    parameter int ADDR_W    = 2,
    parameter int NUM_PORTS = 3
) (
    input  logic        clock,
    input  logic        reset,
    router_fsm_if.slave bus
);
    import router_pkg::*;

    localparam int SEL_W = 2 ** ADDR_W;

    state_t state, state_nxt;

    // Flags padded to the full address range so any address indexes safely;
    // the padding reads as "not empty / no soft reset".
    logic [SEL_W-1:0] empty_pad;
    logic [SEL_W-1:0] srst_pad;
    logic             addr_ok;
    logic             hdr_empty;
    logic             q_empty;
    logic             q_srst;

    assign empty_pad = {{(SEL_W-NUM_PORTS){1'b0}}, bus.fifo_empty};
    assign srst_pad  = {{(SEL_W-NUM_PORTS){1'b0}}, bus.soft_reset};
    assign addr_ok   = (bus.data_in != ADDR_W'(ADDR_INVALID));
    assign hdr_empty = empty_pad[bus.data_in];
    assign q_empty   = empty_pad[bus.addr_q];
    assign q_srst    = srst_pad[bus.addr_q];

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= DECODE_ADDRESS;
        else       state <= state_nxt;
    end

    // Next-state logic; a soft reset of the selected FIFO overrides all.
    always_comb begin
        state_nxt = state;
        unique case (state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid && addr_ok)
                    state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
                else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
            end
            LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
                else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
                else                        state_nxt = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
                if (q_empty) state_nxt = LOAD_FIRST_DATA;
            end
            default: state_nxt = DECODE_ADDRESS;
        endcase
        if (q_srst && state != DECODE_ADDRESS)
            state_nxt = DECODE_ADDRESS;
    end

    // Header address latch: captured whenever a valid header is seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            bus.addr_q <= '0;
        else if (state == DECODE_ADDRESS && bus.pkt_valid && addr_ok)
            bus.addr_q <= bus.data_in;
    end

    // Moore output decode.
    always_comb begin
        bus.detect_add    = (state == DECODE_ADDRESS);
        bus.lfd_state     = (state == LOAD_FIRST_DATA);
        bus.ld_state      = (state == LOAD_DATA);
        bus.laf_state     = (state == LOAD_AFTER_FULL);
        bus.full_state    = (state == FIFO_FULL_STATE);
        bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                            (state == LOAD_AFTER_FULL);
        bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
    end

endmodule
